// File: rtl/temp_spi_pkg.sv
// Shared definitions for the SPI temperature reader: FSM encoding, word widths
// and averaging constants.
package temp_spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_t;

   localparam int TEMP_W    = 9;
   localparam int AVG_N     = 4;
   localparam int AVG_SHIFT = 2;
   localparam int ACC_W     = TEMP_W + AVG_SHIFT;

   function automatic logic [ACC_W-1:0] widen_temp(input logic [TEMP_W-1:0] t);
      return {{AVG_SHIFT{1'b0}}, t};
   endfunction

endpackage

// File: rtl/temp_spi_reader_clk_div.sv
// SCLK half-period timebase: one-cycle half tick every CLK_DIV cycles while
// enabled; the count restarts from zero whenever the enable drops.
module spi_clk_div #(
   parameter int CLK_DIV = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   output logic o_half_tick
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || !i_en) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_half_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/temp_spi_reader.sv
// Read-only mode-0 SPI temperature reader with one-cycle ready pulse.
// Optional TEMP_SPI_AVG_EN: report the average of every 4 captures instead.
module temp_spi_reader
   import temp_spi_pkg::*;
#(
   parameter int CLK_DIV    = 50,
   parameter int FRAME_BITS = 16,
   parameter int TEMP_LSB   = 6,
   parameter int GAP_CYCLES = 100
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic              miso_i,
   output logic              sclk_o,
   output logic              cs_n_o,
   output logic [TEMP_W-1:0] temperatura_o,
   output logic              listo_o,
   output logic              busy_o
);

   localparam int BW   = $clog2(FRAME_BITS + 1);
   localparam int GW   = $clog2(GAP_CYCLES + 1);
   // Frame bits above the temperature field fall off the top, so only the
   // field and the bits below it are kept.
   localparam int SR_W = TEMP_LSB + TEMP_W;

   state_t              r_state;
   logic [SR_W-1:0]     r_shift;
   logic [BW-1:0]       r_bit_cnt;
   logic [GW-1:0]       r_gap_cnt;
   logic                r_sclk;
   logic                r_cs_n;
   logic                r_listo;
   logic                r_busy;
   logic [TEMP_W-1:0]   r_temp;

   logic                w_div_en;
   logic                w_tick;
   logic [TEMP_W-1:0]   w_field;
   logic [SR_W-1:0]     w_shift_in;

   assign w_div_en   = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);
   assign w_shift_in = {r_shift[SR_W-2:0], miso_i};

   generate
      for (genvar gi = 0; gi < TEMP_W; gi++) begin : g_field
         assign w_field[gi] = r_shift[TEMP_LSB + gi];
      end
   endgenerate

   spi_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk         (clk),
      .rst         (rst),
      .i_en        (w_div_en),
      .o_half_tick (w_tick)
   );

`ifdef TEMP_SPI_AVG_EN
   localparam logic [AVG_SHIFT-1:0] AVG_LAST = AVG_SHIFT'(AVG_N - 1);
   logic [ACC_W-1:0]     r_acc;
   logic [AVG_SHIFT-1:0] r_avg_cnt;
   logic [ACC_W-1:0]     w_sum;
   assign w_sum = r_acc + widen_temp(w_field);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_sclk    <= 1'b0;
         r_cs_n    <= 1'b1;
         r_listo   <= 1'b0;
         r_busy    <= 1'b0;
         r_temp    <= '0;
`ifdef TEMP_SPI_AVG_EN
         r_acc     <= '0;
         r_avg_cnt <= '0;
`endif
      end else begin
         r_listo <= 1'b0;
         case (r_state)
            IDLE: begin
               if (en_i) begin
                  r_state   <= SETUP;
                  r_cs_n    <= 1'b0;
                  r_busy    <= 1'b1;
                  r_bit_cnt <= '0;
               end
            end
            SETUP: begin
               // The first rising edge also samples the first bit.
               if (w_tick) begin
                  r_state   <= SHIFT;
                  r_sclk    <= 1'b1;
                  r_shift   <= w_shift_in;
                  r_bit_cnt <= BW'(1);
               end
            end
            SHIFT: begin
               if (w_tick) begin
                  if (r_sclk) begin
                     r_sclk <= 1'b0;
                  end else if (r_bit_cnt == BW'(FRAME_BITS)) begin
                     r_state <= HOLD;
                  end else begin
                     r_sclk    <= 1'b1;
                     r_shift   <= w_shift_in;
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (w_tick) begin
                  r_state   <= GAP;
                  r_cs_n    <= 1'b1;
                  r_gap_cnt <= '0;
`ifdef TEMP_SPI_AVG_EN
                  if (r_avg_cnt == AVG_LAST) begin
                     r_temp    <= w_sum[ACC_W-1:AVG_SHIFT];
                     r_listo   <= 1'b1;
                     r_acc     <= '0;
                     r_avg_cnt <= '0;
                  end else begin
                     r_acc     <= w_sum;
                     r_avg_cnt <= r_avg_cnt + 1'b1;
                  end
`else
                  r_temp  <= w_field;
                  r_listo <= 1'b1;
`endif
               end
            end
            GAP: begin
               if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign sclk_o        = r_sclk;
   assign cs_n_o        = r_cs_n;
   assign temperatura_o = r_temp;
   assign listo_o       = r_listo;
   assign busy_o        = r_busy;

endmodule
